// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

  localparam int unsigned SERIAL_SUB_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// fs_cell: combinational single-bit full subtractor.
// Computes a - b - bi as a difference bit and a borrow out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial d = a - b, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is 0.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned W = SERIAL_SUB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bo,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t r_state;
  state_t w_next;

  logic [W-1:0]  r_sa;
  logic [W-1:0]  r_sb;
  logic [W-1:0]  r_d;
  logic [CW-1:0] r_cnt;
  logic          r_br;
  logic          r_bo;

  logic w_load;
  logic w_last;
  logic w_diff;
  logic w_bout;

  assign w_load = start &&
                  ((r_state == IDLE) || (r_state == DONE));
  assign w_last = (r_state == SHIFT) && (r_cnt == LAST);

  fs_cell u_cell (
    .a  (r_sa[0]),
    .b  (r_sb[0]),
    .bi (r_br),
    .d  (w_diff),
    .bo (w_bout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: start only counts in IDLE/DONE; SHIFT runs W cycles.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands, then feed the cell one bit pair per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_br  <= 1'b0;
      r_bo  <= 1'b0;
    end else if (w_load) begin
      r_sa  <= a;
      r_sb  <= b;
      r_d   <= '0;
      r_cnt <= '0;
      r_br  <= 1'b0;
    end else if (r_state == SHIFT) begin
      r_sa  <= {1'b0, r_sa[W-1:1]};
      r_sb  <= {1'b0, r_sb[W-1:1]};
      r_d   <= {w_diff, r_d[W-1:1]};
      r_br  <= w_bout;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_bo <= w_bout;
    end
  end

  assign d  = r_d;
  assign bo = r_bo;

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Signed overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_last) r_ovf <= r_br ^ w_bout;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor.
// Expected results are queued at start and checked when done pulses.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
  logic         ovf;

  exp_t q[$];
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   n_done;
  int   last_done_cyc;

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    logic [W:0] full;
    full = {1'b0, x} - {1'b0, y};
    e.d  = full[W-1:0];
    e.bo = (x < y);
`ifdef SERIAL_SUB_OVF_EN
    e.ovf = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
`else
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard: every done pops one expected result.
  always @(negedge clk) begin
    if (done && !rst) begin
      n_done++;
      last_done_cyc = cyc;
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("d", 32'(d), 32'(e.d));
        check("bo", 32'(bo), 32'(e.bo));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  // Drive one start at a negedge; returns the cycle count of acceptance.
  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y,
                      output int acc);
    start = 1'b1;
    a = x;
    b = y;
    q.push_back(model(x, y));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    acc = cyc;
  endtask

  // Wait (bounded) for done at a negedge; returns the cycle it was seen.
  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 4 * W; i++) begin
      if (done) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) check("timeout", 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] x,
                        input logic [W-1:0] y);
    int acc;
    int at;
    send(x, y, acc);
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(at);
    if (at >= 0) check("latency", 32'(at - acc), 32'(W));
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int at;
    int at2;
    int nd;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    n_done = 0;
    last_done_cyc = 0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_d", 32'(d), 32'd0);
    check("rst_bo", 32'(bo), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    run_op(8'd200, 8'd55);
    run_op(8'd5, 8'd10);
    run_op(8'h80, 8'h01);
    run_op(8'h7F, 8'hFF);
    run_op(8'h00, 8'h00);

    // Back-to-back: hold start in the DONE cycle.
    send(8'h3C, 8'h3C, acc);
    wait_done(at);
    if (at >= 0) begin
      send(8'h00, 8'h01, acc);
      wait_done(at2);
      if (at2 >= 0) check("b2b_gap", 32'(at2 - at), 32'(W + 1));
    end
    @(negedge clk);

    // Start during SHIFT must be ignored.
    nd = n_done;
    send(8'd100, 8'd30, acc);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'd1;
    b = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(at);
    repeat (2 * W) @(negedge clk);
    check("one_done", 32'(n_done - nd), 32'd1);
    check("idle_after", 32'(busy), 32'd0);

    // Reset mid-operation aborts with no done.
    nd = n_done;
    send(8'd77, 8'd33, acc);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    check("abort_d", 32'(d), 32'd0);
    check("abort_bo", 32'(bo), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * W) @(negedge clk);
    check("abort_no_done", 32'(n_done - nd), 32'd0);
    run_op(8'd9, 8'd4);

    for (int i = 0; i < 8; i++) begin
      run_op(8'($urandom), 8'($urandom));
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
